// File: rtl/fractal_sync_rsp.sv
// Barrier-synchronisation responder for two child ports (a, b).
//
// Each child issues sync requests carrying a target level and a barrier id.
// A barrier completes once both children have synced on it. Completed
// barriers are queued in a small FIFO, and each one is released as a
// simultaneous wake pulse on both ports. Malformed requests are answered with
// an error pulse on the offending port. These are invalid level, double sync
// and FIFO overflow.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   sync_p_i, level_p_i, id_p_i    request pulse, level, barrier id (p = a, b)
//   wake_p_o                       barrier released (both ports together)
//   level_p_o, id_p_o              response level / id (0 when idle)
//   error_p_o                      request on this port was rejected
module fractal_sync_rsp #(
    parameter int unsigned LVL_WIDTH  = 2,
    parameter int unsigned LVL_OFFSET = 1,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned ID_OFFSET  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          sync_a_i,
    input  logic [LVL_WIDTH-1:0]          level_a_i,
    input  logic [ID_WIDTH-1:0]           id_a_i,
    input  logic                          sync_b_i,
    input  logic [LVL_WIDTH-1:0]          level_b_i,
    input  logic [ID_WIDTH-1:0]           id_b_i,
    output logic                          wake_a_o,
    output logic [LVL_WIDTH-LVL_OFFSET-1:0] level_a_o,
    output logic [ID_WIDTH+ID_OFFSET-1:0] id_a_o,
    output logic                          error_a_o,
    output logic                          wake_b_o,
    output logic [LVL_WIDTH-LVL_OFFSET-1:0] level_b_o,
    output logic [ID_WIDTH+ID_OFFSET-1:0] id_b_o,
    output logic                          error_b_o
);

    localparam int unsigned NumBar = 2 ** ID_WIDTH;
    localparam int unsigned LvlOW  = LVL_WIDTH - LVL_OFFSET;
    localparam int unsigned IdOW   = ID_WIDTH + ID_OFFSET;
    localparam int unsigned EntW   = LvlOW + ID_WIDTH;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;

    // FIFO entry: {response level, barrier id}
    logic [EntW-1:0]   mem_q [FIFO_DEPTH];
    logic [EntW-1:0]   mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [NumBar-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;

    logic              wake_q, wake_d;
    logic              err_a_q, err_a_d, err_b_q, err_b_d;
    logic [LvlOW-1:0]  lvl_a_q, lvl_a_d, lvl_b_q, lvl_b_d;
    logic [IdOW-1:0]   id_a_q, id_a_d, id_b_q, id_b_d;

    logic              fresh_a, fresh_b, rej_a, rej_b, simult, cmp_a, cmp_b;
    logic              pop, bypass, ovf_a, ovf_b;
    logic [EntW-1:0]   ent_a, ent_b, e0, head;
    int unsigned       cnt, n_cmp, space, n_acc, n_wr;

    always_comb begin
        // A fresh request is well-formed and its pend bit is still clear;
        // every other sync is rejected (bad level or double sync).
        fresh_a = sync_a_i && (level_a_i == LVL_WIDTH'(1)) && !pend_a_q[id_a_i];
        fresh_b = sync_b_i && (level_b_i == LVL_WIDTH'(1)) && !pend_b_q[id_b_i];
        rej_a   = sync_a_i && !fresh_a;
        rej_b   = sync_b_i && !fresh_b;

        // Before this cycle no barrier has both bits set, so only the ids
        // touched by fresh requests can complete now.
        simult = fresh_a && fresh_b && (id_a_i == id_b_i);
        cmp_a  = fresh_a && (pend_b_q[id_a_i] || simult);
        cmp_b  = fresh_b && pend_a_q[id_b_i];

        ent_a = {level_a_i[LVL_WIDTH-1:LVL_OFFSET], id_a_i};
        ent_b = {level_b_i[LVL_WIDTH-1:LVL_OFFSET], id_b_i};
        e0    = cmp_a ? ent_a : ent_b;   // a-completed entry goes first
        n_cmp = 32'(cmp_a) + 32'(cmp_b);
        cnt   = 32'(count_q);

        // Pop is tried first. An overflow error would itself stall the pop,
        // so room is re-evaluated without it whenever pushes do not fit.
        pop   = ((cnt != 0) || (n_cmp != 0)) && !rej_a && !rej_b;
        space = FIFO_DEPTH - cnt + ((pop && cnt != 0) ? 1 : 0);
        if (n_cmp > space) begin
            pop   = 1'b0;
            space = FIFO_DEPTH - cnt;
        end
        n_acc = (n_cmp < space) ? n_cmp : space;

        ovf_a = 1'b0;
        ovf_b = (n_cmp == 2) && (n_acc < 2);
        if (n_cmp >= 1 && n_acc == 0) begin
            ovf_a = cmp_a;
            ovf_b = ovf_b | (cmp_a ? simult : 1'b1);
        end

        // An empty FIFO hands this cycle's first completion straight to the
        // output, giving single-cycle sync-to-wake latency.
        bypass = pop && (cnt == 0);
        head   = bypass ? e0 : mem_q[rd_ptr_q];
        n_wr   = n_acc - (bypass ? 1 : 0);

        mem_d = mem_q;
        if (n_wr >= 1) mem_d[wr_ptr_q] = bypass ? ent_b : e0;
        if (n_wr >= 2) mem_d[wr_ptr_q + PtrW'(1)] = ent_b;
        wr_ptr_d = wr_ptr_q + PtrW'(n_wr);
        rd_ptr_d = rd_ptr_q + PtrW'((pop && !bypass) ? 1 : 0);
        count_d  = CntW'(cnt + n_wr - ((pop && !bypass) ? 1 : 0));

        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        if (fresh_a) pend_a_d[id_a_i] = 1'b1;
        if (fresh_b) pend_b_d[id_b_i] = 1'b1;
        if (cmp_a) begin
            pend_a_d[id_a_i] = 1'b0;
            pend_b_d[id_a_i] = 1'b0;
        end
        if (cmp_b) begin
            pend_a_d[id_b_i] = 1'b0;
            pend_b_d[id_b_i] = 1'b0;
        end

        // Errors and wakes are exclusive: any error forces pop low.
        wake_d  = pop;
        err_a_d = rej_a | ovf_a;
        err_b_d = rej_b | ovf_b;
        lvl_a_d = '0;
        id_a_d  = '0;
        lvl_b_d = '0;
        id_b_d  = '0;
        if (pop) begin
            lvl_a_d = head[EntW-1:ID_WIDTH];
            lvl_b_d = head[EntW-1:ID_WIDTH];
            id_a_d  = IdOW'(head[ID_WIDTH-1:0]);
            id_b_d  = IdOW'(head[ID_WIDTH-1:0]);
        end
        if (err_a_d) begin
            lvl_a_d = level_a_i[LVL_WIDTH-1:LVL_OFFSET];
            id_a_d  = IdOW'(id_a_i);
        end
        if (err_b_d) begin
            lvl_b_d = level_b_i[LVL_WIDTH-1:LVL_OFFSET];
            id_b_d  = IdOW'(id_b_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pend_a_q <= '0;
            pend_b_q <= '0;
            wake_q   <= 1'b0;
            err_a_q  <= 1'b0;
            err_b_q  <= 1'b0;
            lvl_a_q  <= '0;
            lvl_b_q  <= '0;
            id_a_q   <= '0;
            id_b_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            wake_q   <= wake_d;
            err_a_q  <= err_a_d;
            err_b_q  <= err_b_d;
            lvl_a_q  <= lvl_a_d;
            lvl_b_q  <= lvl_b_d;
            id_a_q   <= id_a_d;
            id_b_q   <= id_b_d;
        end
    end

    assign wake_a_o  = wake_q;
    assign wake_b_o  = wake_q;
    assign error_a_o = err_a_q;
    assign error_b_o = err_b_q;
    assign level_a_o = lvl_a_q;
    assign level_b_o = lvl_b_q;
    assign id_a_o    = id_a_q;
    assign id_b_o    = id_b_q;

endmodule
